// File: rtl/mem_access_ctrl.sv
// Load/store sequencer: decodes MIPS load/store, drives a req/ready data-memory access, returns extended load data.
// Latency: request accepted in cycle N, mem_req from N+1, load wb_valid at N+2 (store completes N+1) when ready is immediate.
// Backpressure: o_stall is high whenever the FSM is not IDLE; upstream holds its inputs while it is high.
//
// Ports:
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_valid, i_opcode, i_address,
//   i_write_data, i_rt,
//   i_MemRead/i_MemWrite/i_MemToReg   EX-stage request and its controls
//   o_stall                      pipeline hold
//   o_mem_req/we/addr/be/wdata   data-memory request side
//   i_mem_ready, i_mem_rdata     data-memory completion side
//   o_wb_valid/we/rd/data        write-back of load results
//   o_misaligned, o_bus_error    one-cycle error pulses
module mem_access_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    input  logic [5:0]  i_opcode,
    input  logic [31:0] i_address,
    input  logic [31:0] i_write_data,
    input  logic [4:0]  i_rt,
    input  logic        i_MemRead,
    input  logic        i_MemWrite,
    input  logic        i_MemToReg,
    output logic        o_stall,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [29:0] o_mem_addr,
    output logic [3:0]  o_mem_be,
    output logic [31:0] o_mem_wdata,
    input  logic        i_mem_ready,
    input  logic [31:0] i_mem_rdata,
    output logic        o_wb_valid,
    output logic        o_wb_we,
    output logic [4:0]  o_wb_rd,
    output logic [31:0] o_wb_data,
    output logic        o_misaligned,
    output logic        o_bus_error
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    // access size encoding
    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    state_t      r_state;
    state_t      w_next_state;

    logic [CNT_W-1:0] r_cnt;
    logic        r_we;
    logic [29:0] r_addr;
    logic [1:0]  r_lane;
    logic [3:0]  r_be;
    logic [31:0] r_wdata;
    logic [1:0]  r_size;
    logic        r_signed;
    logic [4:0]  r_rd;
    logic        r_mem_to_reg;
    logic [31:0] r_wb_data;
    logic        r_misaligned;
    logic        r_bus_error;

    logic [1:0]  w_size;
    logic        w_signed;
    logic        w_aligned;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic        w_req;
    logic        w_accept;
    logic        w_misalign;
    logic        w_timeout;
    logic [7:0]  w_lane_byte;
    logic [15:0] w_lane_half;
    logic [31:0] w_load_ext;

    // Request decode. Direction picks which opcode table applies, so an
    // unrecognised opcode (or a load opcode with MemWrite) falls back to word.
    always_comb begin
        w_size   = SZ_W;
        w_signed = 1'b0;
        if (i_MemWrite) begin
            case (i_opcode)
                6'h28:   w_size = SZ_B;
                6'h29:   w_size = SZ_H;
                default: w_size = SZ_W;
            endcase
        end else begin
            case (i_opcode)
                6'h20:   begin w_size = SZ_B; w_signed = 1'b1; end
                6'h21:   begin w_size = SZ_H; w_signed = 1'b1; end
                6'h24:   w_size = SZ_B;
                6'h25:   w_size = SZ_H;
                default: w_size = SZ_W;
            endcase
        end

        case (w_size)
            SZ_B: begin
                w_aligned = 1'b1;
                w_be      = 4'b0001 << i_address[1:0];
                w_wdata   = {4{i_write_data[7:0]}};
            end
            SZ_H: begin
                w_aligned = ~i_address[0];
                w_be      = i_address[1] ? 4'b1100 : 4'b0011;
                w_wdata   = {2{i_write_data[15:0]}};
            end
            default: begin
                w_aligned = (i_address[1:0] == 2'b00);
                w_be      = 4'hF;
                w_wdata   = i_write_data;
            end
        endcase
    end

    assign w_req      = i_valid & (i_MemRead | i_MemWrite) & (r_state == S_IDLE);
    assign w_accept   = w_req & w_aligned;
    assign w_misalign = w_req & ~w_aligned;

    // Lane selection and extension of the returned read word.
    always_comb begin
        case (r_lane)
            2'd0:    w_lane_byte = i_mem_rdata[7:0];
            2'd1:    w_lane_byte = i_mem_rdata[15:8];
            2'd2:    w_lane_byte = i_mem_rdata[23:16];
            default: w_lane_byte = i_mem_rdata[31:24];
        endcase
        w_lane_half = r_lane[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];
        case (r_size)
            SZ_B:    w_load_ext = r_signed ? {{24{w_lane_byte[7]}}, w_lane_byte}
                                           : {24'h0, w_lane_byte};
            SZ_H:    w_load_ext = r_signed ? {{16{w_lane_half[15]}}, w_lane_half}
                                           : {16'h0, w_lane_half};
            default: w_load_ext = i_mem_rdata;
        endcase
    end

    // FSM state register
    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_next_state;
    end

    // FSM next state and state-decoded outputs
    always_comb begin
        w_next_state = r_state;
        w_timeout    = 1'b0;
        o_mem_req    = 1'b0;
        o_stall      = 1'b0;
        o_wb_valid   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_next_state = S_ACCESS;
            end
            S_ACCESS: begin
                o_mem_req = 1'b1;
                o_stall   = 1'b1;
                if (i_mem_ready) begin
                    w_next_state = r_we ? S_IDLE : S_RESP;
                end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                    w_next_state = S_IDLE;
                    w_timeout    = 1'b1;
                end
            end
            S_RESP: begin
                o_stall      = 1'b1;
                o_wb_valid   = 1'b1;
                w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Request capture, timeout counter, load data and error pulses
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt        <= '0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_lane       <= '0;
            r_be         <= '0;
            r_wdata      <= '0;
            r_size       <= SZ_W;
            r_signed     <= 1'b0;
            r_rd         <= '0;
            r_mem_to_reg <= 1'b0;
            r_wb_data    <= '0;
            r_misaligned <= 1'b0;
            r_bus_error  <= 1'b0;
        end else begin
            r_misaligned <= w_misalign;
            r_bus_error  <= w_timeout;
            if (w_accept) begin
                r_cnt        <= '0;
                r_we         <= i_MemWrite;
                r_addr       <= i_address[31:2];
                r_lane       <= i_address[1:0];
                r_be         <= w_be;
                r_wdata      <= w_wdata;
                r_size       <= w_size;
                r_signed     <= w_signed;
                r_rd         <= i_rt;
                r_mem_to_reg <= i_MemToReg;
            end else if (r_state == S_ACCESS && !i_mem_ready) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (r_state == S_ACCESS && i_mem_ready && !r_we) begin
                r_wb_data <= w_load_ext;
            end
        end
    end

    assign o_mem_we     = r_we;
    assign o_mem_addr   = r_addr;
    assign o_mem_be     = r_be;
    assign o_mem_wdata  = r_wdata;
    assign o_wb_we      = o_wb_valid & r_mem_to_reg;
    assign o_wb_rd      = r_rd;
    assign o_wb_data    = r_wb_data;
    assign o_misaligned = r_misaligned;
    assign o_bus_error  = r_bus_error;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Testbench for mem_access_ctrl: directed load/store/error scenarios plus randomized traffic.
// Expected values come from a byte-oriented reference model of the load/store rules.
// Inputs are driven and outputs sampled 1 time unit after each rising clock edge.
module tb_mem_access_ctrl;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_valid;
    logic [5:0]  i_opcode;
    logic [31:0] i_address;
    logic [31:0] i_write_data;
    logic [4:0]  i_rt;
    logic        i_MemRead;
    logic        i_MemWrite;
    logic        i_MemToReg;
    logic        o_stall;
    logic        o_mem_req;
    logic        o_mem_we;
    logic [29:0] o_mem_addr;
    logic [3:0]  o_mem_be;
    logic [31:0] o_mem_wdata;
    logic        i_mem_ready;
    logic [31:0] i_mem_rdata;
    logic        o_wb_valid;
    logic        o_wb_we;
    logic [4:0]  o_wb_rd;
    logic [31:0] o_wb_data;
    logic        o_misaligned;
    logic        o_bus_error;

    int n_checks = 0;
    int n_fail   = 0;

    mem_access_ctrl #(.TIMEOUT(16), .CNT_W(5)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_opcode(i_opcode),
        .i_address(i_address), .i_write_data(i_write_data), .i_rt(i_rt),
        .i_MemRead(i_MemRead), .i_MemWrite(i_MemWrite), .i_MemToReg(i_MemToReg),
        .o_stall(o_stall), .o_mem_req(o_mem_req), .o_mem_we(o_mem_we),
        .o_mem_addr(o_mem_addr), .o_mem_be(o_mem_be), .o_mem_wdata(o_mem_wdata),
        .i_mem_ready(i_mem_ready), .i_mem_rdata(i_mem_rdata),
        .o_wb_valid(o_wb_valid), .o_wb_we(o_wb_we), .o_wb_rd(o_wb_rd),
        .o_wb_data(o_wb_data), .o_misaligned(o_misaligned), .o_bus_error(o_bus_error)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    function automatic int size_of(logic [5:0] op, logic wr);
        if (wr) return (op == 6'h28) ? 1 : (op == 6'h29) ? 2 : 4;
        return (op == 6'h20 || op == 6'h24) ? 1 : (op == 6'h21 || op == 6'h25) ? 2 : 4;
    endfunction

    function automatic logic model_aligned(logic [5:0] op, logic wr, logic [31:0] a);
        return (a % size_of(op, wr)) == 0;
    endfunction

    function automatic logic [3:0] model_be(logic [5:0] op, logic wr, logic [31:0] a);
        int sz = size_of(op, wr);
        return 4'(((1 << sz) - 1) << (a % 4));
    endfunction

    // each memory byte lane i carries data byte (i mod size)
    function automatic logic [31:0] model_wdata(logic [5:0] op, logic [31:0] d);
        int sz = size_of(op, 1'b1);
        logic [31:0] r = 0;
        for (int i = 0; i < 4; i++) r = r | (((d >> (8 * (i % sz))) & 32'hFF) << (8 * i));
        return r;
    endfunction

    function automatic logic [31:0] model_load(logic [5:0] op, logic [31:0] a, logic [31:0] rd);
        int sz = size_of(op, 1'b0);
        logic sgn = (op == 6'h20 || op == 6'h21);
        logic [31:0] v;
        if (sz == 4) return rd;
        v = (rd >> (8 * (a % 4))) & ((32'h1 << (8 * sz)) - 1);
        if (sgn && v[8 * sz - 1]) v = v | ~((32'h1 << (8 * sz)) - 1);
        return v;
    endfunction

    task automatic drive_req(logic [5:0] op, logic rd, logic wr, logic m2r,
                             logic [31:0] a, logic [31:0] d, logic [4:0] rt);
        i_valid = 1'b1; i_opcode = op; i_MemRead = rd; i_MemWrite = wr;
        i_MemToReg = m2r; i_address = a; i_write_data = d; i_rt = rt;
    endtask

    task automatic idle_inputs();
        i_valid = 1'b0; i_MemRead = 1'b0; i_MemWrite = 1'b0; i_MemToReg = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        i_rst = 1'b1; idle_inputs(); i_opcode = 0; i_address = 0; i_write_data = 0;
        i_rt = 0; i_mem_ready = 1'b0; i_mem_rdata = 0;
        tick(); tick();
        n_checks++;
        if ({o_stall, o_mem_req, o_mem_we, o_wb_valid, o_wb_we, o_misaligned, o_bus_error} !== 7'b0) begin
            n_fail++; $display("FAIL reset_ctrl: got %b want 0000000",
                {o_stall, o_mem_req, o_mem_we, o_wb_valid, o_wb_we, o_misaligned, o_bus_error});
        end
        n_checks++;
        if ({o_mem_addr, o_mem_be, o_mem_wdata, o_wb_rd, o_wb_data} !== 103'b0) begin
            n_fail++; $display("FAIL reset_data: addr=%h be=%h wdata=%h rd=%h wbdata=%h want all 0",
                o_mem_addr, o_mem_be, o_mem_wdata, o_wb_rd, o_wb_data);
        end
        i_rst = 1'b0;
        tick();
    endtask

    task automatic test_store_word();
        i_mem_ready = 1'b1;
        drive_req(6'h2B, 1'b0, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 5'd0);
        tick(); idle_inputs();
        n_checks++;
        if ({o_mem_req, o_mem_we, o_stall, o_mem_addr, o_mem_be, o_mem_wdata} !== {3'b111, 30'h4, 4'hF, 32'hDEADBEEF}) begin
            n_fail++; $display("FAIL sw_access: req=%b we=%b stall=%b addr=%h be=%h wdata=%h want 1 1 1 4 f deadbeef",
                o_mem_req, o_mem_we, o_stall, o_mem_addr, o_mem_be, o_mem_wdata);
        end
        tick();
        n_checks++;
        if ({o_stall, o_mem_req, o_wb_valid} !== 3'b000) begin
            n_fail++; $display("FAIL sw_done: stall/req/wbv=%b want 000", {o_stall, o_mem_req, o_wb_valid});
        end
        i_mem_ready = 1'b0;
    endtask

    task automatic test_store_sub();
        logic [5:0]  ops [2] = '{6'h28, 6'h29};
        logic [31:0] adr [2] = '{32'h13, 32'h12};
        logic [31:0] dat [2] = '{32'h000000A5, 32'h1234BEEF};
        logic [3:0]  ebe [2] = '{4'b1000, 4'b1100};
        logic [31:0] ewd [2] = '{32'hA5A5A5A5, 32'hBEEFBEEF};
        for (int k = 0; k < 2; k++) begin
            i_mem_ready = 1'b1;
            drive_req(ops[k], 1'b0, 1'b1, 1'b0, adr[k], dat[k], 5'd0);
            tick(); idle_inputs();
            n_checks++;
            if ({o_mem_be, o_mem_wdata, o_mem_addr} !== {ebe[k], ewd[k], adr[k][31:2]}) begin
                n_fail++; $display("FAIL store_sub%0d: be=%b wdata=%h addr=%h want %b %h %h",
                    k, o_mem_be, o_mem_wdata, o_mem_addr, ebe[k], ewd[k], adr[k][31:2]);
            end
            tick();
            i_mem_ready = 1'b0;
        end
    endtask

    task automatic test_load_ext();
        logic [5:0]  ops [3] = '{6'h20, 6'h24, 6'h25};
        logic [31:0] adr [3] = '{32'h21, 32'h21, 32'h22};
        logic [31:0] rdt [3] = '{32'h00008000, 32'h00008000, 32'h80011234};
        logic [31:0] exp [3] = '{32'hFFFFFF80, 32'h00000080, 32'h00008001};
        for (int k = 0; k < 3; k++) begin
            i_mem_ready = 1'b1; i_mem_rdata = rdt[k];
            drive_req(ops[k], 1'b1, 1'b0, 1'b1, adr[k], 32'h0, 5'(7 + k));
            tick(); idle_inputs();
            n_checks++;
            if ({o_mem_req, o_mem_we, o_mem_be} !== {2'b10, model_be(ops[k], 1'b0, adr[k])}) begin
                n_fail++; $display("FAIL load_req%0d: req=%b we=%b be=%b", k, o_mem_req, o_mem_we, o_mem_be);
            end
            tick(); i_mem_ready = 1'b0;
            n_checks++;
            if ({o_wb_valid, o_wb_we, o_wb_rd, o_wb_data} !== {2'b11, 5'(7 + k), exp[k]}) begin
                n_fail++; $display("FAIL load_wb%0d: v=%b we=%b rd=%0d data=%h want 1 1 %0d %h",
                    k, o_wb_valid, o_wb_we, o_wb_rd, o_wb_data, 7 + k, exp[k]);
            end
            tick();
            n_checks++;
            if ({o_wb_valid, o_stall} !== 2'b00) begin
                n_fail++; $display("FAIL load_pulse%0d: wb_valid/stall=%b want 00", k, {o_wb_valid, o_stall});
            end
        end
    endtask

    task automatic test_misaligned();
        int seen_req = 0;
        int seen_wb = 0;
        i_mem_ready = 1'b1;
        drive_req(6'h23, 1'b1, 1'b0, 1'b1, 32'h06, 32'h0, 5'd3);
        tick(); idle_inputs();
        n_checks++;
        if ({o_misaligned, o_mem_req, o_stall} !== 3'b100) begin
            n_fail++; $display("FAIL misalign_pulse: mis/req/stall=%b want 100", {o_misaligned, o_mem_req, o_stall});
        end
        tick();
        n_checks++;
        if (o_misaligned !== 1'b0) begin
            n_fail++; $display("FAIL misalign_width: misaligned=%b want 0", o_misaligned);
        end
        for (int c = 0; c < 4; c++) begin
            if (o_mem_req === 1'b1) seen_req++;
            if (o_wb_valid === 1'b1) seen_wb++;
            tick();
        end
        n_checks++;
        if (seen_req + seen_wb != 0) begin
            n_fail++; $display("FAIL misalign_noaccess: req cycles=%0d wb cycles=%0d want 0 0", seen_req, seen_wb);
        end
        i_mem_ready = 1'b0;
    endtask

    task automatic test_timeout();
        int cyc = 0;
        int early_err = 0;
        i_mem_ready = 1'b0;
        drive_req(6'h23, 1'b1, 1'b0, 1'b1, 32'h40, 32'h0, 5'd4);
        tick(); idle_inputs();
        while (o_mem_req === 1'b1 && cyc < 40) begin
            if (o_bus_error === 1'b1) early_err++;
            cyc++;
            tick();
        end
        n_checks++;
        if (cyc != 16 || early_err != 0) begin
            n_fail++; $display("FAIL timeout_len: req cycles=%0d early bus_error=%0d want 16 0", cyc, early_err);
        end
        n_checks++;
        if ({o_bus_error, o_stall, o_wb_valid} !== 3'b100) begin
            n_fail++; $display("FAIL timeout_pulse: err/stall/wbv=%b want 100", {o_bus_error, o_stall, o_wb_valid});
        end
        tick();
        n_checks++;
        if (o_bus_error !== 1'b0) begin
            n_fail++; $display("FAIL timeout_width: bus_error=%b want 0", o_bus_error);
        end
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        i_mem_ready = 1'b0;
        drive_req(6'h23, 1'b1, 1'b0, 1'b1, 32'h80, 32'h0, 5'd9);
        tick(); idle_inputs();
        tick(); tick();
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        n_checks++;
        if ({o_mem_req, o_stall, o_mem_be} !== 6'b0) begin
            n_fail++; $display("FAIL rst_mid: req=%b stall=%b be=%h want 0 0 0", o_mem_req, o_stall, o_mem_be);
        end
        i_mem_ready = 1'b1; i_mem_rdata = 32'h12345678;
        for (int c = 0; c < 3; c++) begin
            if (o_mem_req === 1'b1 || o_wb_valid === 1'b1 || o_stall === 1'b1) seen++;
            tick();
        end
        i_mem_ready = 1'b0;
        n_checks++;
        if (seen != 0) begin
            n_fail++; $display("FAIL rst_late_ready: active cycles=%0d want 0", seen);
        end
    endtask

    task automatic test_back_to_back();
        i_mem_ready = 1'b1; i_mem_rdata = 32'hCAFEF00D;
        drive_req(6'h2B, 1'b0, 1'b1, 1'b0, 32'h100, 32'h11223344, 5'd0);
        tick(); idle_inputs();
        tick();
        drive_req(6'h23, 1'b1, 1'b0, 1'b1, 32'h200, 32'h0, 5'd21);
        tick(); idle_inputs();
        n_checks++;
        if ({o_mem_req, o_mem_we, o_mem_addr} !== {2'b10, 30'h80}) begin
            n_fail++; $display("FAIL b2b_accept: req=%b we=%b addr=%h want 1 0 80", o_mem_req, o_mem_we, o_mem_addr);
        end
        tick();
        n_checks++;
        if ({o_wb_valid, o_wb_rd, o_wb_data} !== {1'b1, 5'd21, 32'hCAFEF00D}) begin
            n_fail++; $display("FAIL b2b_wb: v=%b rd=%0d data=%h want 1 21 cafef00d", o_wb_valid, o_wb_rd, o_wb_data);
        end
        tick();
        i_mem_ready = 1'b0;
    endtask

    task automatic test_random();
        logic [5:0] optab [10] = '{6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B, 6'h00, 6'h3F};
        for (int it = 0; it < 200; it++) begin
            logic [5:0]  op = optab[$urandom_range(0, 9)];
            int          ctl = $urandom_range(0, 7);
            logic        rd = (ctl inside {1, 2, 3, 6});
            logic        wr = (ctl inside {4, 5, 6, 7});
            logic        m2r = 1'($urandom);
            logic [31:0] a = $urandom;
            logic [31:0] d = $urandom;
            logic [4:0]  rt = 5'($urandom);
            logic [31:0] rdata = $urandom;
            int          dly = $urandom_range(0, 3);
            if ($urandom_range(0, 2) != 0) a[1:0] = 2'b00;
            i_mem_ready = 1'($urandom);
            drive_req(op, rd, wr, m2r, a, d, rt);
            tick(); idle_inputs();
            if (!rd && !wr) begin
                n_checks++;
                if ({o_stall, o_mem_req, o_misaligned} !== 3'b000) begin
                    n_fail++; $display("FAIL rnd_ignore it%0d: stall/req/mis=%b want 000", it,
                        {o_stall, o_mem_req, o_misaligned});
                end
            end else if (!model_aligned(op, wr, a)) begin
                n_checks++;
                if ({o_misaligned, o_mem_req, o_stall} !== 3'b100) begin
                    n_fail++; $display("FAIL rnd_misalign it%0d op=%h a=%h: mis/req/stall=%b want 100", it, op, a,
                        {o_misaligned, o_mem_req, o_stall});
                end
            end else begin
                for (int c = 0; c <= dly; c++) begin
                    i_mem_ready = (c == dly);
                    i_mem_rdata = (c == dly) ? rdata : 32'($urandom);
                    n_checks++;
                    if ({o_mem_req, o_stall, o_mem_we, o_mem_addr, o_mem_be} !==
                        {2'b11, wr, a[31:2], model_be(op, wr, a)} ||
                        (wr && o_mem_wdata !== model_wdata(op, d))) begin
                        n_fail++; $display("FAIL rnd_access it%0d op=%h wr=%b a=%h: req=%b we=%b addr=%h be=%b wdata=%h want be=%b wdata=%h",
                            it, op, wr, a, o_mem_req, o_mem_we, o_mem_addr, o_mem_be, o_mem_wdata,
                            model_be(op, wr, a), model_wdata(op, d));
                    end
                    tick();
                end
                i_mem_ready = 1'b0;
                if (!wr) begin
                    n_checks++;
                    if ({o_wb_valid, o_wb_we, o_wb_rd, o_wb_data, o_mem_req} !==
                        {1'b1, m2r, rt, model_load(op, a, rdata), 1'b0}) begin
                        n_fail++; $display("FAIL rnd_load it%0d op=%h a=%h rdata=%h: v=%b we=%b rd=%0d data=%h want 1 %b %0d %h",
                            it, op, a, rdata, o_wb_valid, o_wb_we, o_wb_rd, o_wb_data, m2r, rt,
                            model_load(op, a, rdata));
                    end
                    tick();
                end
                n_checks++;
                if ({o_stall, o_mem_req, o_wb_valid} !== 3'b000) begin
                    n_fail++; $display("FAIL rnd_done it%0d: stall/req/wbv=%b want 000", it,
                        {o_stall, o_mem_req, o_wb_valid});
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_store_word();
        test_store_sub();
        test_load_ext();
        test_misaligned();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
